// File: rtl/laser_bank.sv
// laser_bank: per-channel fire/cooldown pulse generator bank; define LASER_BANK_AMMO_EN for per-channel ammo with reload.
module laser_bank #(
  parameter int CHANNELS = 4,
  parameter int CNT_W = 32,
  parameter int ON_CYCLES = 100000000,
  parameter int COOL_CYCLES = 100000000,
  parameter int AMMO = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [CHANNELS-1:0] trig_n,
  input  logic [CHANNELS-1:0] reload,
  output logic [CHANNELS-1:0] laser_out,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] empty
);
  typedef enum logic [1:0] {IDLE, FIRE, COOL} state_t;
  localparam logic [CNT_W-1:0] ON_LAST = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOL_CYCLES - 1);
`ifdef LASER_BANK_AMMO_EN
  localparam int AW = $clog2(AMMO + 1);
`else
  logic unused_reload;
  assign unused_reload = ^reload;
  assign empty = '0;
`endif
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_t st;
    logic [CNT_W-1:0] cnt;
    logic lo, bz, go;
`ifdef LASER_BANK_AMMO_EN
    logic [AW-1:0] ammo, ammo_nx;
    logic emp;
    assign go = !trig_n[c] && enable && ammo != '0;
    // reload wins over the decrement of a simultaneous shot
    assign ammo_nx = reload[c] ? AW'(AMMO) : (st == IDLE && go) ? ammo - 1'b1 : ammo;
    always_ff @(posedge clock) begin
      if (reset) begin
        ammo <= AW'(AMMO);
        emp <= 1'b0;
      end else begin
        ammo <= ammo_nx;
        emp <= ammo_nx == '0;
      end
    end
    assign empty[c] = emp;
`else
    assign go = !trig_n[c] && enable;
`endif
    always_ff @(posedge clock) begin
      if (reset) begin
        st <= IDLE;
        cnt <= '0;
        lo <= 1'b0;
        bz <= 1'b0;
      end else begin
        case (st)
          IDLE: if (go) begin
            st <= FIRE;
            cnt <= '0;
            lo <= 1'b1;
            bz <= 1'b1;
          end
          FIRE: if (!enable || cnt == ON_LAST) begin
            st <= COOL;
            cnt <= '0;
            lo <= 1'b0;
          end else cnt <= cnt + 1'b1;
          COOL: if (cnt == COOL_LAST) begin
            st <= IDLE;
            cnt <= '0;
            bz <= 1'b0;
          end else cnt <= cnt + 1'b1;
          default: begin
            st <= IDLE;
            cnt <= '0;
            lo <= 1'b0;
            bz <= 1'b0;
          end
        endcase
      end
    end
    assign laser_out[c] = lo;
    assign busy[c] = bz;
  end
endmodule

// File: tb/tb_laser_bank.sv
// tb_laser_bank: scoreboard bench for laser_bank with CHANNELS=2, ON=4, COOL=3, AMMO=2.
module tb_laser_bank;
`ifdef LASER_BANK_AMMO_EN
  localparam bit AMMO_ON = 1'b1;
`else
  localparam bit AMMO_ON = 1'b0;
`endif
  logic clock, reset, enable;
  logic [1:0] trig_n, reload, laser_out, busy, empty;
  typedef struct {logic [1:0] lo, bz, em; string nm;} exp_t;
  exp_t q[$];
  int passed = 0, total = 0;

  laser_bank #(.CHANNELS(2), .CNT_W(32), .ON_CYCLES(4), .COOL_CYCLES(3), .AMMO(2)) dut (
    .clock(clock), .reset(reset), .enable(enable), .trig_n(trig_n), .reload(reload),
    .laser_out(laser_out), .busy(busy), .empty(empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if ({laser_out, busy, empty} !== {e.lo, e.bz, e.em})
        $display("FAIL %s: laser_out=%b busy=%b empty=%b, required laser_out=%b busy=%b empty=%b",
                 e.nm, laser_out, busy, empty, e.lo, e.bz, e.em);
      else passed++;
    end
  end

  task automatic v(input bit r, e, input logic [1:0] t, l, lo, bz, em, input string nm);
    @(negedge clock);
    #1;
    reset = r;
    enable = e;
    trig_n = t;
    reload = l;
    q.push_back('{lo, bz, em, nm});
  endtask

  task automatic pulse(input logic [1:0] m, input logic [1:0] rl, input string nm);
    v(0, 1, ~m, rl, m, m, 2'b00, nm);
    for (int k = 0; k < 3; k++) v(0, 1, 2'b11, 2'b00, m, m, 2'b00, nm);
    for (int k = 0; k < 3; k++) v(0, 1, 2'b11, 2'b00, 2'b00, m, 2'b00, nm);
    for (int k = 0; k < 2; k++) v(0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, nm);
  endtask

  // trigger held low: period 8 (4 on, 3 cool, 1 idle); ammo runs out after two shots
  task automatic held(input int ch, input int nper, input string nm);
    logic [1:0] m;
    m = 2'(1 << ch);
    for (int p = 0; p < nper; p++)
      for (int k = 0; k < 8; k++) begin
        bit f;
        f = !AMMO_ON || p < 2;
        v(0, 1, ~m, 2'b00, (f && k < 4) ? m : 2'b00, (f && k < 7) ? m : 2'b00,
          (AMMO_ON && p >= 1) ? m : 2'b00, nm);
      end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    trig_n = 2'b11;
    reload = 2'b00;
    v(1, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, "reset");
    v(1, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, "reset");
    pulse(2'b01, 2'b00, "pulse");
    v(1, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, "reset");
    held(1, 2, "held");
    v(0, 1, 2'b11, 2'b00, 2'b00, 2'b00, AMMO_ON ? 2'b10 : 2'b00, "held_rel");
    v(1, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, "reset");
    v(0, 1, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, "abort");
    v(0, 1, 2'b11, 2'b00, 2'b01, 2'b01, 2'b00, "abort");
    v(0, 0, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00, "abort");
    v(0, 0, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, "abort");
    v(0, 0, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, "abort");
    v(0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, "abort");
    v(0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, "disabled");
    v(0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, "disabled");
    v(1, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, "reset");
    v(0, 1, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, "rst_fire");
    v(0, 1, 2'b11, 2'b00, 2'b01, 2'b01, 2'b00, "rst_fire");
    v(1, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, "rst_fire");
    pulse(2'b01, 2'b00, "after_rst");
    v(1, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, "reset");
    pulse(2'b11, 2'b00, "simul");
    v(1, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, "reset");
    held(0, 3, "ammo");
    v(0, 1, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, "reload");
    pulse(2'b01, 2'b01, "reload_fire");
    held(0, 3, "ammo2");
    v(0, 1, 2'b11, 2'b00, 2'b00, 2'b00, AMMO_ON ? 2'b01 : 2'b00, "ammo2_rel");
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      @(negedge clock);
      #1;
    end
    if (q.size() > 0) begin
      total++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/laser_bank.md
LASER_BANK -- requirements
Module: laser_bank

Interface
REQ-001 Parameter CHANNELS, 4, number of independent laser channels (1..16).
REQ-002 Parameter CNT_W, 32, width of each per-channel phase counter.
REQ-003 Parameter ON_CYCLES, 100000000, laser-on duration in clock cycles (>=1, < 2^CNT_W).
REQ-004 Parameter COOL_CYCLES, 100000000, cooldown duration in clock cycles (>=1, < 2^CNT_W).
REQ-005 Parameter AMMO, 8, shots per channel between reloads (>=1); used only with LASER_BANK_AMMO_EN.
REQ-006 Port clock  input  1  single system clock; all logic on posedge.
REQ-007 Port reset  input  1  synchronous, active-high reset.
REQ-008 Port enable  input  1  global arm; 0 blocks new shots and aborts active shots.
REQ-009 Port trig_n  input  CHANNELS  per-channel fire request, active-low, level-sampled.
REQ-010 Port reload  input  CHANNELS  per-channel ammo refill pulse, active-high.
REQ-011 Port laser_out  output  CHANNELS  per-channel laser drive, active-high, registered.
REQ-012 Port busy  output  CHANNELS  1 while channel is in FIRE or COOL, registered.
REQ-013 Port empty  output  CHANNELS  1 when channel ammo is 0; constant 0 without LASER_BANK_AMMO_EN.

Function
REQ-014 Each channel SHALL run an independent FSM with states IDLE, FIRE, COOL and a CNT_W-bit counter.
REQ-015 IDLE -> FIRE when trig_n[i]==0, enable==1 and (no ammo feature or ammo>0), sampled on a clock edge; counter loads 0.
REQ-016 laser_out[i] SHALL be 1 starting the cycle after the firing edge and for exactly ON_CYCLES cycles.
REQ-017 FIRE -> COOL when counter reaches ON_CYCLES-1; counter reloads 0; laser_out[i] drops on the same edge.
REQ-018 COOL SHALL last exactly COOL_CYCLES cycles with laser_out[i]==0, then return to IDLE.
REQ-019 trig_n SHALL be ignored in FIRE and COOL; a trigger held low continuously re-fires on the first IDLE cycle, giving period ON_CYCLES+COOL_CYCLES+1.
REQ-020 enable==0 in FIRE SHALL force FIRE -> COOL (counter 0, full cooldown) on the next edge; laser_out drops that edge.
REQ-021 enable==0 SHALL NOT interrupt COOL; the channel completes cooldown then waits in IDLE.
REQ-022 busy[i] SHALL equal (state != IDLE), updated on the same edge as the state.
REQ-023 Channels SHALL be fully independent; simultaneous triggers on all channels all fire on the same edge.
REQ-024 Counters SHALL never wrap; comparisons use full CNT_W width.

Reset
REQ-025 On reset==1 at a clock edge: every channel -> IDLE, counter 0, laser_out 0, busy 0.
REQ-026 With LASER_BANK_AMMO_EN, reset SHALL load ammo=AMMO for every channel and empty=0.
REQ-027 Reset asserted mid-FIRE or mid-COOL SHALL take priority over all other events and abort immediately.
REQ-028 No output SHALL depend on initial blocks; all state defined by reset.

Configuration
REQ-029 Macro LASER_BANK_AMMO_EN SHALL compile in per-channel ammo counters of width ceil(log2(AMMO+1)).
REQ-030 With the macro: each IDLE -> FIRE decrements ammo by 1; ammo==0 blocks firing; empty[i]=(ammo==0), registered.
REQ-031 With the macro: reload[i]==1 sets ammo to AMMO next edge in any state; reload on the same edge as a fire yields ammo=AMMO (reload wins, shot still fires).
REQ-032 Without the macro: no ammo logic, reload ignored, empty tied 0, shots unlimited.

Verification (CHANNELS=2, ON_CYCLES=4, COOL_CYCLES=3, AMMO=2)
REQ-033 Single pulse: trig_n[0] low 1 cycle at edge T -> laser_out[0]=1 for cycles T+1..T+4, busy[0]=1 for T+1..T+7, 0 at T+8.
REQ-034 Held trigger: trig_n[1] low continuously -> laser_out[1] period 8 cycles, 4 high; trig_n[0]=1 -> channel 0 stays idle.
REQ-035 Abort: enable dropped at edge T+2 of a shot -> laser_out low from T+2, busy stays 1 for 3 more cycles, then 0.
REQ-036 Reset mid-FIRE at cycle T+2 -> laser_out=0, busy=0 next edge; trigger after reset fires normally.
REQ-037 Ammo (macro on): three held-trigger shots requested -> only 2 fire, empty[0]=1; reload pulse -> empty=0, next shot fires.
REQ-038 Simultaneous: both trig_n low same edge -> both laser_out rise same cycle, identical timing.
